uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   Serial receiver; counterpart of the UART transmitter on the far end of the link.
//   Samples rx_line: 8N1 framing, LSB first, idle high.
//   Delivers each good byte on rx_data with a one-cycle rx_done strobe.
//   Flags a bad stop bit on frame_err. Shares baud parameters with the TX so that
//   loopback (tx_line -> rx_line) works with no further configuration.
// PARAMETERS
//   clk_freq   50000000  system clock frequency, Hz
//   baud_rate  9600      line rate, bits/s
//   derived: clks_per_bit = clk_freq/baud_rate (integer divide); half_bit = clks_per_bit/2
//   legal range: 4 <= clks_per_bit <= 65535 (16-bit counter)
// PORTS
//   clk        in   1  system clock; all logic on rising edge
//   reset_n    in   1  asynchronous, active-low reset
//   rx_line    in   1  asynchronous serial input, idle high
//   rx_data    out  8  last good received byte; holds until the next good byte
//   rx_done    out  1  one-cycle pulse: rx_data has just been updated
//   rx_busy    out  1  high from start-bit detection until return to IDLE
//   frame_err  out  1  one-cycle pulse: stop bit sampled low
// BEHAVIOUR
//   Reset (reset_n=0, async):
//     - state=IDLE; both synchroniser flops=1; counters=0.
//     - rx_data=8'h00; rx_done=0; rx_busy=0; frame_err=0.
//   Synchroniser: 2 flops on rx_line, giving rx_s. All decisions use rx_s only.
//   State machine (clk_count 16-bit, bit_index 3-bit):
//     IDLE:  when rx_s=0, go to START; clk_count=0; rx_busy=1.
//     START: clk_count increments. At clk_count==half_bit-1, re-check rx_s:
//              - rx_s=0: go to DATA; clk_count=0; bit_index=0.
//              - rx_s=1: false start; go to IDLE; rx_busy=0; no strobe.
//     DATA:  at clk_count==clks_per_bit-1:
//              - shift_reg[bit_index]=rx_s; clk_count=0.
//              - after bit_index==7, go to STOP; otherwise bit_index+1.
//     STOP:  at clk_count==clks_per_bit-1, sample rx_s:
//              - rx_s=1: rx_data=shift_reg; rx_done=1 for one cycle; go to IDLE.
//              - rx_s=0: frame_err=1 for one cycle; rx_data unchanged; go to BRK.
//     BRK:   stay until rx_s=1, then go to IDLE. A held-low line (break) never
//            produces a second frame or a second frame_err.
//   rx_busy: 1 in START/DATA/STOP/BRK. Drops on the same edge that sets rx_done,
//     on a false start, or on leaving BRK.
//   Latency: number edges from the first edge that samples rx_line low (= edge 1).
//     rx_done is high after edge 3 + half_bit + 9*clks_per_bit.
//   Back-to-back frames: a start bit arriving directly after the stop sample is
//     accepted (IDLE detects it on the next rx_s=0 cycle). No idle gap is required.
//   rx_done and frame_err are never high together. Neither is ever high for 2 cycles.
//   A reset mid-frame aborts the frame: no strobe, rx_data returns to 8'h00.
//     After reset is released, a line still low is treated as a new start (START check).
// TESTING (bench uses clk_freq=16, baud_rate=1: clks_per_bit=16, half_bit=8)
//   Loopback from the TX, send 8'hA5 -> one rx_done pulse after 155 edges,
//     rx_data=8'hA5, frame_err never 1.
//   Back-to-back 8'h00 then 8'hFF with no idle gap -> two rx_done pulses,
//     rx_data 8'h00 then 8'hFF.
//   Glitch: rx_line low for 3 cycles, then high -> no rx_done, no frame_err;
//     rx_busy 1 then 0; next valid frame received correctly.
//   Frame 8'h3C with stop bit driven low, line then held low 100 cycles ->
//     exactly one frame_err; rx_data keeps its prior value; IDLE after line goes high.
//   reset_n pulsed low during bit 4 of a frame -> outputs at reset values,
//     no rx_done; following frame 8'h5A received correctly.
//   Bit-time skew: TX bits 15 and 17 cycles wide -> 8'hC3 still received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, framing-error and break handling.
// rx_data holds the last good byte; rx_done and frame_err are single-cycle strobes.
module uart_rx #(
  parameter int clk_freq  = 50000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int clks_per_bit = clk_freq / baud_rate;
  localparam int half_bit     = clks_per_bit / 2;
  localparam logic [15:0] bit_last  = 16'(clks_per_bit - 1);
  localparam logic [15:0] half_last = 16'(half_bit - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t      state;
  logic        sync_meta;
  logic        rx_s;
  logic [15:0] clk_count;
  logic [2:0]  bit_index;
  logic [7:0]  shift_reg;

  // Synchroniser resets to the idle level so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      sync_meta <= rx_line;
      rx_s      <= sync_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      clk_count <= 16'd0;
      bit_index <= 3'd0;
      shift_reg <= 8'h00;
      rx_data   <= 8'h00;
      rx_done   <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state     <= START;
            clk_count <= 16'd0;
            rx_busy   <= 1'b1;
          end
        end

        START: begin
          // Re-check at mid start bit; a short low pulse is rejected as a glitch.
          if (clk_count == half_last) begin
            clk_count <= 16'd0;
            if (!rx_s) begin
              state     <= DATA;
              bit_index <= 3'd0;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end

        DATA: begin
          if (clk_count == bit_last) begin
            clk_count            <= 16'd0;
            shift_reg[bit_index] <= rx_s;
            if (bit_index == 3'd7) begin
              state <= STOP;
            end else begin
              bit_index <= bit_index + 3'd1;
            end
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end

        STOP: begin
          if (clk_count == bit_last) begin
            clk_count <= 16'd0;
            if (rx_s) begin
              rx_data <= shift_reg;
              rx_done <= 1'b1;
              rx_busy <= 1'b0;
              state   <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end

        BRK: begin
          // Wait out a held-low line so a break reports only once.
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames driven bit by bit; expected strobes are queued
// by the stimulus and checked by an independent monitor.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_line = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;

  uart_rx #(
    .clk_freq (16),
    .baud_rate(1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_line  (rx_line),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_busy  (rx_busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input int at_cyc);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    e.cyc    = at_cyc;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input logic [7:0] held);
    exp_t e;
    e.is_err = 1'b1;
    e.data   = held;
    e.cyc    = 0;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input int w);
    rx_line = v;
    repeat (w) @(negedge clk);
  endtask

  // Start bit plus eight data bits, LSB first; the caller drives the stop bit.
  task automatic send_body(input logic [7:0] b, input int w);
    drive(1'b0, w);
    for (int i = 0; i < 8; i++) drive(b[i], w);
  endtask

  task automatic send_frame(input logic [7:0] b, input int w);
    send_body(b, w);
    drive(1'b1, w);
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_done || frame_err) begin
        check("done_and_err_together", {31'd0, rx_done & frame_err}, 32'd0);
        check("strobe_two_cycles", {31'd0, (rx_done & prev_done) | (frame_err & prev_err)}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {24'd0, rx_data}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_kind", {31'd0, frame_err}, {31'd0, e.is_err});
          check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
          if (e.cyc != 0) check("done_latency", cyc, e.cyc);
          $display("rx %s data=%02h cycle=%0d", frame_err ? "frame_err" : "byte", rx_data, cyc);
        end
      end
      prev_done <= rx_done;
      prev_err  <= frame_err;
    end else begin
      prev_done <= 1'b0;
      prev_err  <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_rx_done", {31'd0, rx_done}, 32'd0);
    check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single frame with latency: edge 1 is the next posedge, done after edge 155.
    expect_byte(8'hA5, cyc + 155);
    send_frame(8'hA5, 16);
    repeat (10) @(negedge clk);

    // Back-to-back, no idle gap.
    expect_byte(8'h00, 0);
    expect_byte(8'hFF, 0);
    send_frame(8'h00, 16);
    send_frame(8'hFF, 16);
    repeat (10) @(negedge clk);

    // Glitch rejected, then a clean frame.
    drive(1'b0, 3);
    check("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
    drive(1'b1, 20);
    check("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
    expect_byte(8'h69, 0);
    send_frame(8'h69, 16);
    repeat (10) @(negedge clk);

    // Bad stop bit followed by a long break: one frame_err, data held.
    expect_err(8'h69);
    send_body(8'h3C, 16);
    drive(1'b0, 116);
    check("break_busy_high", {31'd0, rx_busy}, 32'd1);
    check("break_data_held", {24'd0, rx_data}, 32'h69);
    drive(1'b1, 5);
    check("break_idle_busy", {31'd0, rx_busy}, 32'd0);
    repeat (10) @(negedge clk);

    // Reset during bit 4 of a frame aborts it.
    drive(1'b0, 16);
    for (int i = 0; i < 4; i++) drive(1'b0, 16);
    drive(1'b1, 8);
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset_rx_data", {24'd0, rx_data}, 32'h00);
    check("midreset_rx_busy", {31'd0, rx_busy}, 32'd0);
    check("midreset_rx_done", {31'd0, rx_done}, 32'd0);
    check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 40);
    check("after_reset_data", {24'd0, rx_data}, 32'h00);
    expect_byte(8'h5A, 0);
    send_frame(8'h5A, 16);
    repeat (10) @(negedge clk);

    // Transmitter clock skew: short and long bit times.
    expect_byte(8'hC3, 0);
    send_frame(8'hC3, 15);
    drive(1'b1, 20);
    expect_byte(8'hC3, 0);
    send_frame(8'hC3, 17);

    repeat (60) @(negedge clk);
    check("expected_strobes_left", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
